gpio_seq_checker: RTL and testbench

Parametrised on-chip GPIO sequence checker for the user project area. It samples a WIDTH-bit slice of mprj_io inputs, synchronises and debounces it, and checks each stable value change against a programmable table of expected values. It reports pass/fail, the failing step and value, and a timeout. This lets the bring-up pattern that the GPIO testbench applies from outside (all-Z, then 00, FF, 00) be checked by the chip itself, for any width, pattern length and settle time.

---
 rtl/gpio_seq_checker_if.sv | 41 ++++
 rtl/gpio_seq_checker.sv | 165 ++++++++++++++++
 tb/tb_gpio_seq_checker.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_seq_checker_if.sv
// Bus bundle for gpio_seq_checker.
// Groups the pad inputs, the expected-value table write port, the run
// configuration/start controls and the status outputs.
//   master : drives gpio_in, exp_we/exp_addr/exp_data, exp_len, tmo_cycles,
//            start; observes busy, pass, fail, timeout, step_idx,
//            fail_value, cur_value.
//   slave  : the checker itself (opposite directions).
// Parameters must match those of the gpio_seq_checker instance.
interface gpio_seq_checker_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TMO_W = 16
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] gpio_in;
  logic             exp_we;
  logic [AW-1:0]    exp_addr;
  logic [WIDTH-1:0] exp_data;
  logic [LW-1:0]    exp_len;
  logic [TMO_W-1:0] tmo_cycles;
  logic             start;
  logic             busy;
  logic             pass;
  logic             fail;
  logic             timeout;
  logic [LW-1:0]    step_idx;
  logic [WIDTH-1:0] fail_value;
  logic [WIDTH-1:0] cur_value;

  modport master (
    output gpio_in, exp_we, exp_addr, exp_data, exp_len, tmo_cycles, start,
    input  busy, pass, fail, timeout, step_idx, fail_value, cur_value
  );

  modport slave (
    input  gpio_in, exp_we, exp_addr, exp_data, exp_len, tmo_cycles, start,
    output busy, pass, fail, timeout, step_idx, fail_value, cur_value
  );
endinterface

// File: rtl/gpio_seq_checker.sv
// On-chip GPIO sequence checker.
// Synchronises and debounces a WIDTH-bit slice of pad inputs and checks each
// accepted value change against a programmable table of expected values.
// Ports:
//   clock   : system clock, all state on the rising edge
//   resetb  : asynchronous active-low reset (table is not cleared)
//   bus     : gpio_seq_checker_if.slave -- pad inputs, table write port,
//             run config (exp_len, tmo_cycles, start) and registered status
//             (busy, pass, fail, timeout, step_idx, fail_value, cur_value)
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | after reset, waiting for start
// RUN   | checking change events against the table
// DONE  | holding pass/fail result until next start
module gpio_seq_checker #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE      = 4,
  parameter int TMO_W       = 16
) (
  input  logic             clock,
  input  logic             resetb,
  gpio_seq_checker_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(STABLE + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] cur_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_nxt;
  logic             accept;
  logic [WIDTH-1:0] tbl [DEPTH];
  logic             exp_hit;

  state_t           state_q;
  logic             busy_q, pass_q, fail_q, tmo_q;
  logic [LW-1:0]    step_q;
  logic [LW-1:0]    len_q;
  logic [WIDTH-1:0] fval_q;
  logic [TMO_W-1:0] tlim_q;
  logic [TMO_W-1:0] tmr_q;

  assign synced = sync_q[SYNC_STAGES-1];

  // cnt_nxt = number of consecutive cycles (saturating at STABLE) the
  // synchronised value has held, including the one being sampled now.
  always_comb begin
    cnt_nxt = CW'(1);
    if (synced == ref_q) begin
      cnt_nxt = (cnt_q == CW'(STABLE)) ? cnt_q : cnt_q + CW'(1);
    end
  end

  assign accept  = (cnt_nxt == CW'(STABLE)) && (synced != cur_q);
  assign exp_hit = (synced == tbl[step_q[AW-1:0]]);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      ref_q <= '0;
      cnt_q <= '0;
      cur_q <= '0;
    end else begin
      sync_q[0] <= bus.gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      ref_q <= synced;
      cnt_q <= cnt_nxt;
      if (accept) cur_q <= synced;
    end
  end

  // Expected table: survives reset on purpose so a run can be re-armed
  // after a reset without reprogramming.
  always_ff @(posedge clock) begin
    if (bus.exp_we && (state_q != RUN)) tbl[bus.exp_addr] <= bus.exp_data;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tmo_q   <= 1'b0;
      step_q  <= '0;
      len_q   <= '0;
      fval_q  <= '0;
      tlim_q  <= '0;
      tmr_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            tmo_q  <= 1'b0;
            fval_q <= '0;
            step_q <= '0;
            len_q  <= bus.exp_len;
            tlim_q <= bus.tmo_cycles;
            tmr_q  <= bus.tmo_cycles;
            if (bus.exp_len == '0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              pass_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          // An accepted change takes priority over timer expiry.
          if (accept) begin
            if (exp_hit) begin
              step_q <= step_q + LW'(1);
              tmr_q  <= tlim_q;
              if (step_q + LW'(1) == len_q) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                pass_q  <= 1'b1;
              end
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              fail_q  <= 1'b1;
              fval_q  <= synced;
            end
          end else if (tlim_q != '0) begin
            // Expire on the tlim_q-th edge after arming.
            if (tmr_q == TMO_W'(1)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              fail_q  <= 1'b1;
              tmo_q   <= 1'b1;
              fval_q  <= '0;
            end else begin
              tmr_q <= tmr_q - TMO_W'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.pass       = pass_q;
  assign bus.fail       = fail_q;
  assign bus.timeout    = tmo_q;
  assign bus.step_idx   = step_q;
  assign bus.fail_value = fval_q;
  assign bus.cur_value  = cur_q;
endmodule

// File: tb/tb_gpio_seq_checker.sv
// Testbench for gpio_seq_checker: directed scenarios plus randomized runs,
// with a scoreboard fed by a high-level model of debounced change events
// and run outcomes.
module tb_gpio_seq_checker;
  logic clock;
  logic resetb;

  gpio_seq_checker_if #(.WIDTH(8), .DEPTH(4), .TMO_W(16)) bus ();

  gpio_seq_checker #(
    .WIDTH(8), .DEPTH(4), .SYNC_STAGES(2), .STABLE(4), .TMO_W(16)
  ) dut (
    .clock  (clock),
    .resetb (resetb),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       p;
    logic       f;
    logic       t;
    logic [2:0] step;
    logic [7:0] fv;
    logic       ev;
  } res_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ev_q [$];
  res_t       res_q [$];

  // reference model state
  logic [7:0] m_cur;
  logic       m_run;
  int         m_step;
  int         m_len;
  logic [7:0] m_tbl [4];

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t mk_res(input logic p, input logic f, input logic t,
                                  input int step, input logic [7:0] fv, input logic ev);
    res_t r;
    r.p = p; r.f = f; r.t = t; r.step = 3'(step); r.fv = fv; r.ev = ev;
    return r;
  endfunction

  // A stable value that differs from the accepted one is one change event;
  // during a run it either matches the next table entry or ends the run.
  task automatic apply(input logic [7:0] v);
    bus.gpio_in = v;
    if (v != m_cur) begin
      ev_q.push_back(v);
      m_cur = v;
      if (m_run) begin
        if (v == m_tbl[m_step]) begin
          m_step++;
          if (m_step == m_len) begin
            res_q.push_back(mk_res(1'b1, 1'b0, 1'b0, m_step, 8'h00, 1'b1));
            m_run = 1'b0;
          end
        end else begin
          res_q.push_back(mk_res(1'b0, 1'b1, 1'b0, m_step, v, 1'b1));
          m_run = 1'b0;
        end
      end
    end
  endtask

  task automatic glitch(input logic [7:0] g, input int n);
    bus.gpio_in = g;
    tick(n);
    bus.gpio_in = m_cur;
    tick(1);
  endtask

  task automatic write_tbl(input int a, input logic [7:0] d);
    bus.exp_addr = 2'(a);
    bus.exp_data = d;
    bus.exp_we   = 1'b1;
    tick(1);
    bus.exp_we   = 1'b0;
    if (!m_run) m_tbl[a] = d;
  endtask

  task automatic do_start(input int len, input int tmo);
    bus.exp_len    = 3'(len);
    bus.tmo_cycles = 16'(tmo);
    bus.start      = 1'b1;
    tick(1);
    bus.start      = 1'b0;
    if (!m_run) begin
      if (len == 0) begin
        res_q.push_back(mk_res(1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0));
      end else begin
        m_run  = 1'b1;
        m_step = 0;
        m_len  = len;
      end
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy && k < 300) begin
      tick(1);
      k++;
    end
    check("idle_wait", {31'd0, bus.busy}, 32'd0);
  endtask

  function automatic logic [7:0] rand_ne(input logic [7:0] x);
    logic [7:0] v;
    v = 8'($urandom);
    if (v == x) v = ~x;
    return v;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a new accepted
  // value or a new pass/fail result.
  logic [7:0] prev_cur;
  logic       prev_pass, prev_fail;
  logic       cur_chg;
  logic [7:0] exp_ev;
  res_t       exp_r, act_r;

  always @(negedge clock) begin
    if (!resetb) begin
      prev_cur  = 8'h00;
      prev_pass = 1'b0;
      prev_fail = 1'b0;
    end else begin
      cur_chg = (bus.cur_value != prev_cur);
      if (cur_chg) begin
        n_checks++;
        if (ev_q.size() == 0) begin
          n_fail++;
          $display("FAIL event: got cur_value %0h expected no event", bus.cur_value);
        end else begin
          exp_ev = ev_q.pop_front();
          if (bus.cur_value !== exp_ev) begin
            n_fail++;
            $display("FAIL event: got cur_value %0h expected %0h", bus.cur_value, exp_ev);
          end
        end
      end
      if ((bus.pass && !prev_pass) || (bus.fail && !prev_fail)) begin
        act_r = mk_res(bus.pass, bus.fail, bus.timeout, int'(bus.step_idx), bus.fail_value, cur_chg);
        n_checks++;
        if (res_q.size() == 0) begin
          n_fail++;
          $display("FAIL result: got %0h expected no result", act_r);
        end else begin
          exp_r = res_q.pop_front();
          if (act_r !== exp_r || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL result: got %0h busy %0b expected %0h busy 0", act_r, bus.busy, exp_r);
          end
        end
      end
      prev_cur  = bus.cur_value;
      prev_pass = bus.pass;
      prev_fail = bus.fail;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  int         r_len;
  logic [7:0] r_prev, r_v;

  initial begin
    resetb         = 1'b0;
    bus.gpio_in    = 8'h00;
    bus.exp_we     = 1'b0;
    bus.exp_addr   = '0;
    bus.exp_data   = '0;
    bus.exp_len    = '0;
    bus.tmo_cycles = '0;
    bus.start      = 1'b0;
    m_cur = 8'h00; m_run = 1'b0; m_step = 0; m_len = 0;
    for (int i = 0; i < 4; i++) m_tbl[i] = 8'h00;
    tick(2);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_pass", {31'd0, bus.pass}, 0);
    check("rst_fail", {31'd0, bus.fail}, 0);
    check("rst_timeout", {31'd0, bus.timeout}, 0);
    check("rst_step", {29'd0, bus.step_idx}, 0);
    check("rst_fval", {24'd0, bus.fail_value}, 0);
    check("rst_cur", {24'd0, bus.cur_value}, 0);
    resetb = 1'b1;
    tick(1);

    // Bring-up pattern 00, FF, 00 starting from FF.
    write_tbl(0, 8'h00); write_tbl(1, 8'hFF); write_tbl(2, 8'h00);
    apply(8'hFF); tick(20);
    do_start(3, 0);
    check("start_busy", {31'd0, bus.busy}, 1);
    apply(8'h00); tick(20);
    apply(8'hFF); tick(20);
    apply(8'h00); tick(5);
    check("pass_early", {31'd0, bus.pass}, 0);
    tick(1);
    check("pass_lat6", {31'd0, bus.pass}, 1);
    check("pass_step", {29'd0, bus.step_idx}, 3);
    tick(14);

    // Mismatch at step 1.
    apply(8'hFF); tick(20);
    do_start(3, 0);
    apply(8'h00); tick(20);
    apply(8'h0F); tick(20);
    check("mm_fail", {31'd0, bus.fail}, 1);
    check("mm_fval", {24'd0, bus.fail_value}, 32'h0F);
    check("mm_step", {29'd0, bus.step_idx}, 1);
    check("mm_tmo", {31'd0, bus.timeout}, 0);

    // Timeout exactly 50 edges after start.
    write_tbl(0, 8'hA5);
    do_start(1, 50);
    m_run = 1'b0;
    res_q.push_back(mk_res(1'b0, 1'b1, 1'b1, 0, 8'h00, 1'b0));
    tick(49);
    check("tmo_early", {31'd0, bus.fail}, 0);
    tick(1);
    check("tmo_fail", {31'd0, bus.fail}, 1);
    check("tmo_flag", {31'd0, bus.timeout}, 1);
    check("tmo_fval", {24'd0, bus.fail_value}, 0);

    // Timer reloads on a matched step.
    write_tbl(0, 8'h5A); write_tbl(1, 8'h3C);
    do_start(2, 20);
    apply(8'h5A);
    m_run = 1'b0;
    res_q.push_back(mk_res(1'b0, 1'b1, 1'b1, 1, 8'h00, 1'b0));
    tick(25);
    check("reload_early", {31'd0, bus.fail}, 0);
    tick(1);
    check("reload_tmo", {31'd0, bus.timeout}, 1);
    check("reload_step", {29'd0, bus.step_idx}, 1);

    // Glitch rejection.
    apply(8'h00); tick(20);
    write_tbl(0, 8'h3C);
    do_start(1, 0);
    glitch(8'h3C, 3);
    tick(10);
    check("glitch_step", {29'd0, bus.step_idx}, 0);
    check("glitch_busy", {31'd0, bus.busy}, 1);
    apply(8'h3C); tick(10);
    check("glitch_pass", {31'd0, bus.pass}, 1);

    // Reset mid-run after one matched step.
    write_tbl(0, 8'h00); write_tbl(1, 8'hFF); write_tbl(2, 8'h00);
    do_start(3, 0);
    apply(8'h00); tick(10);
    check("mid_step", {29'd0, bus.step_idx}, 1);
    resetb = 1'b0;
    #1;
    check("mr_busy", {31'd0, bus.busy}, 0);
    check("mr_step", {29'd0, bus.step_idx}, 0);
    check("mr_cur", {24'd0, bus.cur_value}, 0);
    check("mr_flags", {29'd0, bus.pass, bus.fail, bus.timeout}, 0);
    check("mr_fval", {24'd0, bus.fail_value}, 0);
    m_cur = 8'h00; m_run = 1'b0;
    tick(2);
    resetb = 1'b1;
    tick(1);

    // exp_len = 0 completes immediately without busy.
    do_start(0, 0);
    check("len0_pass", {31'd0, bus.pass}, 1);
    check("len0_busy", {31'd0, bus.busy}, 0);
    tick(3);
    check("len0_busy_hold", {31'd0, bus.busy}, 0);

    // Old table entry 0 survives reset; writes and start ignored while busy.
    apply(8'hFF); tick(20);
    do_start(1, 0);
    write_tbl(0, 8'h77);
    bus.exp_len = 3'd0;
    bus.start   = 1'b1;
    tick(1);
    bus.start   = 1'b0;
    check("busy_start_ign", {31'd0, bus.busy}, 1);
    check("busy_pass_ign", {31'd0, bus.pass}, 0);
    apply(8'h00); tick(20);
    check("kept_tbl_pass", {31'd0, bus.pass}, 1);
    check("kept_tbl_step", {29'd0, bus.step_idx}, 1);

    // Randomized runs.
    for (int r = 0; r < 12; r++) begin
      r_len  = $urandom_range(1, 4);
      r_prev = m_cur;
      for (int i = 0; i < 4; i++) begin
        r_v = rand_ne(r_prev);
        write_tbl(i, r_v);
        r_prev = r_v;
      end
      do_start(r_len, 0);
      for (int i = 0; i < r_len && m_run; i++) begin
        if ($urandom_range(0, 3) == 0) glitch(rand_ne(m_cur), $urandom_range(1, 3));
        r_v = ($urandom_range(0, 4) == 0) ? rand_ne(m_cur) : m_tbl[i];
        apply(r_v);
        tick($urandom_range(8, 15));
      end
      wait_idle();
    end

    tick(10);
    check("ev_q_empty", ev_q.size(), 0);
    check("res_q_empty", res_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
